// File: rtl/sample_packetizer_pkg.sv
// Shared definitions for the sample packetizer: sync byte, frame length,
// FSM state encoding, the latched frame record and the byte selector that
// turns a frame record into its on-wire bytes.
package sample_packetizer_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  // Everything needed to regenerate any byte of the frame on a retry.
  typedef struct packed {
    logic [15:0] smp;
    logic        ovf;
    logic [6:0]  seq;
  } frame_t;

  // Send order: sync, {ovf, seq}, sample MSB, sample LSB.
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [1:0] idx);
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return {f.ovf, f.seq};
      2'd2:    return f.smp[15:8];
      default: return f.smp[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sample_packetizer_if.sv
// Byte-wide transmit handshake toward the USB FIFO bridge.
//   tx_data_rdy : one-cycle request (packetizer -> bridge)
//   tx_data     : byte, held from request until ack (packetizer -> bridge)
//   tx_ok       : one-cycle accept pulse (bridge -> packetizer)
//   tx_err      : one-cycle reject pulse (bridge -> packetizer)
//   busy        : bridge cannot take a request (bridge -> packetizer)
interface sample_packetizer_if;
  logic       tx_data_rdy;
  logic [7:0] tx_data;
  logic       tx_ok;
  logic       tx_err;
  logic       busy;

  modport master (output tx_data_rdy, tx_data, input tx_ok, tx_err, busy);
  modport slave  (input tx_data_rdy, tx_data, output tx_ok, tx_err, busy);
endinterface

// File: rtl/sample_packetizer_buffer.sv
// sample_buffer: synchronous circular FIFO.
//   push/din   : write strobe and data; ignored when full unless popping too
//   pop/dout   : read strobe; dout is registered and valid the cycle after pop
//   full/empty : occupancy flags
//   level      : number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      dout <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/sample_packetizer.sv
// sample_packetizer: buffers 16-bit ADC samples and sends each one as a
// 4-byte frame (A5, {ovf,seq}, MSB, LSB) over the byte handshake, retrying
// rejected or unacknowledged bytes and aborting after MAX_RETRY failures.
//   clk_i, reset_i   : clock, async active-high reset
//   sample_valid_i   : one-cycle strobe for sample_i
//   sample_i         : ADC sample
//   tx               : transmit handshake (master side)
//   overflow_o       : sticky, a sample was dropped since the last frame start
//   drop_cnt_o       : aborted frame count, saturating
//   level_o          : buffer occupancy
//   frame_active_o   : FSM is not idle
module sample_packetizer
  import sample_packetizer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_GAP   = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     sample_valid_i,
  input  logic [15:0]              sample_i,
  sample_packetizer_if.master      tx,
  output logic                     overflow_o,
  output logic [7:0]               drop_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     frame_active_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GW = (RETRY_GAP > 0) ? $clog2(RETRY_GAP + 1) : 1;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [6:0]      seq_q, seq_d;
  logic [7:0]      drop_q, drop_d;
  logic            ovf_q, ovf_d;
  frame_t          frm_q;

  logic            pop, load, fail, ovf_evt;
  logic            full, empty;
  logic [15:0]     buf_dout;

  sample_buffer #(.W(16), .DEPTH(DEPTH)) u_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (sample_valid_i),
    .pop     (pop),
    .din     (sample_i),
    .dout    (buf_dout),
    .full    (full),
    .empty   (empty),
    .level   (level_o)
  );

  // Only a push that the buffer actually refuses counts as an overflow.
  assign ovf_evt = sample_valid_i && full && !pop;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    retry_d        = retry_q;
    wcnt_d         = wcnt_q;
    gcnt_d         = gcnt_q;
    seq_d          = seq_q;
    drop_d         = drop_q;
    pop            = 1'b0;
    load           = 1'b0;
    fail           = 1'b0;
    tx.tx_data_rdy = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        idx_d   = 2'd0;
        retry_d = '0;
        seq_d   = seq_q + 7'd1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx.busy) begin
          tx.tx_data_rdy = 1'b1;
          wcnt_d         = '0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An error beats a simultaneous ok; timeout behaves like an error.
        fail = tx.tx_err || (ACK_TIMEOUT != 0 && wcnt_q == TW'(ACK_TIMEOUT - 1));
        if (fail) begin
          retry_d = retry_q + 1'b1;
          if (retry_d == RW'(MAX_RETRY)) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            state_d = ST_IDLE;
          end else begin
            gcnt_d  = '0;
            state_d = ST_GAP;
          end
        end else if (tx.tx_ok) begin
          if (idx_q == 2'(FRAME_LEN - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            retry_d = '0;
            state_d = ST_SEND;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(RETRY_GAP)) state_d = ST_SEND;
        else                          gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start hands the flag to the header; a same-cycle drop re-arms it.
    ovf_d = ovf_evt ? 1'b1 : (load ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      frm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      if (load) frm_q <= '{smp: buf_dout, ovf: ovf_q, seq: seq_q};
    end
  end

  assign tx.tx_data     = (state_q == ST_SEND || state_q == ST_WAIT) ? frame_byte(frm_q, idx_q) : 8'h00;
  assign overflow_o     = ovf_q;
  assign drop_cnt_o     = drop_q;
  assign frame_active_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sample_packetizer.sv
module tb_sample_packetizer;
  localparam int DEPTH = 16, MAXR = 3, GAP = 8, TMO = 255;

  logic        clk = 0, rst = 1, sv = 0;
  logic [15:0] smp = 0;
  logic        ovf, act;
  logic [7:0]  drop;
  logic [4:0]  level;

  sample_packetizer_if tx_if();

  sample_packetizer #(.DEPTH(DEPTH), .MAX_RETRY(MAXR), .RETRY_GAP(GAP), .ACK_TIMEOUT(TMO)) dut (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv), .sample_i(smp), .tx(tx_if.master),
    .overflow_o(ovf), .drop_cnt_o(drop), .level_o(level), .frame_active_o(act));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_LOAD, M_ACT} mph_t;
  mph_t        m_ph;
  logic [15:0] mq[$];
  logic [15:0] m_pend, m_smp;
  logic        m_ovf, m_fovf;
  logic [6:0]  m_seq, m_fseq;
  int          m_idx, m_retry, m_wcnt, m_gcnt, m_drop;
  bit          m_send, m_wait;

  function automatic logic [7:0] m_byte(input int i);
    logic [7:0] b [4];
    b[0] = 8'hA5; b[1] = {m_fovf, m_fseq}; b[2] = m_smp[15:8]; b[3] = m_smp[7:0];
    return b[i];
  endfunction

  task automatic m_reset();
    m_ph = M_IDLE; mq.delete(); m_pend = 0; m_smp = 0; m_ovf = 0; m_fovf = 0;
    m_seq = 0; m_fseq = 0; m_idx = 0; m_retry = 0; m_wcnt = 0; m_gcnt = 0;
    m_drop = 0; m_send = 0; m_wait = 0;
  endtask

  task automatic m_step();
    mph_t ph = m_ph;
    int   sz = mq.size();
    bit   pop, evt, fail;
    pop = (ph == M_IDLE) && (sz > 0);
    evt = 0;
    if (pop) begin m_pend = mq.pop_front(); m_ph = M_LOAD; end
    if (sv) begin
      if (sz < DEPTH || pop) mq.push_back(smp);
      else evt = 1;
    end
    if (ph == M_LOAD) begin
      m_smp = m_pend; m_fovf = m_ovf; m_fseq = m_seq; m_seq = m_seq + 7'd1;
      m_ovf = evt; m_idx = 0; m_retry = 0; m_send = 1; m_wait = 0; m_ph = M_ACT;
    end else if (evt) m_ovf = 1;
    if (ph == M_ACT) begin
      if (m_send) begin
        if (!tx_if.busy) begin m_send = 0; m_wait = 1; m_wcnt = 0; end
      end else if (m_wait) begin
        m_wcnt++;
        fail = tx_if.tx_err || (TMO != 0 && m_wcnt == TMO);
        if (fail) begin
          m_wait = 0; m_retry++;
          if (m_retry == MAXR) begin m_ph = M_IDLE; if (m_drop < 255) m_drop++; end
          else m_gcnt = GAP + 1;
        end else if (tx_if.tx_ok) begin
          m_wait = 0;
          if (m_idx == 3) m_ph = M_IDLE;
          else begin m_idx++; m_retry = 0; m_send = 1; end
        end
      end else if (m_gcnt > 0) begin
        m_gcnt--;
        if (m_gcnt == 0) m_send = 1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  bit er;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      er = (m_ph == M_ACT) && m_send && !tx_if.busy;
      chk("rdy", tx_if.tx_data_rdy, er);
      chk("data", tx_if.tx_data, (m_ph == M_ACT && (m_send || m_wait)) ? m_byte(m_idx) : 8'h00);
      chk("active", act, m_ph != M_IDLE);
      chk("level", level, mq.size());
      chk("overflow", ovf, m_ovf);
      chk("drop_cnt", drop, m_drop);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic push(input logic [15:0] d);
    sv = 1; smp = d; tick(); sv = 0;
  endtask

  task automatic get_req(output logic [7:0] b, output int at);
    bit got = 0;
    b = 0; at = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (tx_if.tx_data_rdy === 1'b1) begin got = 1; b = tx_if.tx_data; at = cyc; end
    end
    chk("req_seen", got, 1);
  endtask

  task automatic ack(input bit err, input int dly, output int t);
    repeat (dly) tick();
    if (err) tx_if.tx_err = 1; else tx_if.tx_ok = 1;
    t = cyc;
    tick();
    tx_if.tx_err = 0; tx_if.tx_ok = 0;
  endtask

  task automatic frame_ok(input int dly, output logic [31:0] fb);
    logic [7:0] b; int at, t;
    fb = 0;
    for (int k = 0; k < 4; k++) begin
      get_req(b, at); fb = {fb[23:0], b}; ack(0, dly, t);
    end
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] fb;
    int p, at, at2, t, seen, brel;
    tx_if.tx_ok = 0; tx_if.tx_err = 0; tx_if.busy = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_rdy", tx_if.tx_data_rdy, 0); chk("rst_data", tx_if.tx_data, 0);
    chk("rst_ovf", ovf, 0); chk("rst_drop", drop, 0);
    chk("rst_level", level, 0); chk("rst_active", act, 0);
    rst = 0; tick(); tick();

    // Single sample, acks 2 cycles after each request.
    p = cyc; push(16'h1234);
    get_req(b, at); chk("t1_latency", at - p, 3); chk("t1_b0", b, 8'hA5); ack(0, 2, t);
    get_req(b, at); chk("t1_b1", b, 8'h00); ack(0, 2, t);
    get_req(b, at); chk("t1_b2", b, 8'h12); ack(0, 2, t);
    get_req(b, at); chk("t1_b3", b, 8'h34); ack(0, 2, t);
    repeat (2) tick();
    chk("t1_idle", act, 0); chk("t1_level", level, 0);

    // Overflow: 20 back-to-back pushes while the first frame waits.
    for (int i = 0; i < 20; i++) push(16'h5000 + 16'(i));
    @(negedge clk);
    chk("t2_level_full", level, 16); chk("t2_ovf", ovf, 1);
    ack(0, 1, t);
    get_req(b, at); chk("t2_f1_b1", b, 8'h01); ack(0, 1, t);
    get_req(b, at); ack(0, 1, t);
    get_req(b, at); ack(0, 1, t);
    frame_ok(1, fb); chk("t2_f2", fb, 32'hA5825001);
    frame_ok(1, fb); chk("t2_f3", fb, 32'hA5035002);
    for (int j = 0; j < 14; j++) frame_ok(1, fb);
    tick(); chk("t2_drained", level, 0);

    // One error on byte 2, then ok.
    push(16'hBEEF);
    get_req(b, at); ack(0, 1, t);
    get_req(b, at); chk("t3_b1", b, 8'h12); ack(0, 1, t);
    get_req(b, at); ack(1, 2, t);
    get_req(b, at); chk("t3_retry_gap", at - t, GAP + 2); chk("t3_retry_b", b, 8'hBE); ack(0, 1, t);
    get_req(b, at); chk("t3_b3", b, 8'hEF); ack(0, 1, t);
    tick(); chk("t3_drop", drop, 0);

    // Three errors on byte 1 abort the frame.
    push(16'hCAFE);
    get_req(b, at); ack(0, 1, t);
    for (int r = 0; r < 3; r++) begin
      get_req(b, at); chk("t4_b1", b, 8'h13); ack(1, 1, t);
    end
    tick(); chk("t4_drop", drop, 1); chk("t4_idle", act, 0);
    push(16'h0F0F);
    frame_ok(1, fb); chk("t4_next", fb, 32'hA5140F0F);

    // Busy in SEND for 50 cycles, then no ack -> timeout retry.
    tx_if.busy = 1;
    push(16'h1357);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_if.tx_data_rdy === 1'b1) seen++;
    end
    chk("t5_no_req_busy", seen, 0); chk("t5_active", act, 1);
    @(posedge clk); #1; tx_if.busy = 0; brel = cyc;
    get_req(b, at); chk("t5_release", at - brel, 0); chk("t5_b0", b, 8'hA5);
    get_req(b, at2); chk("t5_timeout_retry", at2 - at, TMO + GAP + 2); chk("t5_retry_b0", b, 8'hA5);
    ack(0, 1, t);
    get_req(b, at); chk("t5_b1", b, 8'h15); ack(0, 1, t);
    get_req(b, at); ack(0, 1, t);
    get_req(b, at); ack(0, 1, t);

    // Reset while waiting on byte 2.
    push(16'h7777);
    get_req(b, at); ack(0, 1, t);
    get_req(b, at); chk("t6_b1", b, 8'h16); ack(0, 1, t);
    get_req(b, at); tick();
    rst = 1; #1;
    chk("t6_rdy", tx_if.tx_data_rdy, 0); chk("t6_data", tx_if.tx_data, 0);
    chk("t6_ovf", ovf, 0); chk("t6_drop", drop, 0);
    chk("t6_level", level, 0); chk("t6_active", act, 0);
    tick(); rst = 0; tick();
    push(16'h4242);
    frame_ok(1, fb); chk("t6_after_reset", fb, 32'hA5004242);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/sample_packetizer.md
# sample_packetizer

Frames 16-bit ADC samples into 4-byte packets and feeds them one byte at a time into the transmit side of `fifo_interface`, the USB FIFO bridge. It sits between the ADC sample source and `fifo_interface`. It buffers samples arriving at the ~41 kHz sample rate, sequences the per-byte transmit handshake, and retries bytes the FIFO rejects. It reports overflow and dropped-frame status to the top level.

## Interface
- `DEPTH`, 16: sample buffer entries; power of two, at least 2.
- `MAX_RETRY`, 3: number of failed attempts on one byte before the frame is aborted.
- `RETRY_GAP`, 8: idle cycles between a failure and the retry.
- `ACK_TIMEOUT`, 255: cycles to wait in WAIT before treating the byte as failed.
- `clk_i` in 1: system clock, the 36 MHz PLL output.
- `reset_i` in 1: asynchronous, active-high reset.
- `sample_valid_i` in 1: one-cycle strobe qualifying `sample_i`.
- `sample_i` in 16: ADC sample.
- `tx_data_rdy_o` out 1: one-cycle request to `fifo_interface`.
- `tx_data_o` out 8: byte to transmit; stable from the request until ack.
- `tx_ok_i` in 1: one-cycle pulse; byte accepted.
- `tx_err_i` in 1: one-cycle pulse; byte rejected.
- `busy_i` in 1: `fifo_interface` is busy; no request may be issued.
- `overflow_o` out 1: sticky; at least one sample dropped since the last frame header.
- `drop_cnt_o` out 8: count of aborted frames, saturating at 255.
- `level_o` out log2(DEPTH)+1: buffer occupancy.
- `frame_active_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Frame format**, in send order:
  - byte 0: 0xA5 (sync).
  - byte 1: {ovf, seq[6:0]}.
  - byte 2: sample[15:8].
  - byte 3: sample[7:0].
- **Sequence number:** `seq` is a 7-bit counter. It increments at every frame start, including frames later aborted, and wraps 127→0.
- **Overflow flag (ovf):**
  - A push while the buffer is full drops the new sample and sets `overflow_o`.
  - A push and a pop in the same cycle on a full buffer is accepted; no overflow.
  - At frame start, `overflow_o` is copied into ovf and then cleared.
  - If an overflow occurs in that same cycle, `overflow_o` stays set.
- **FSM states:** IDLE, LOAD, SEND, WAIT, GAP.
  - IDLE: if the buffer is non-empty, pop and go to LOAD.
  - LOAD: latch sample, ovf and seq into the frame registers; set idx=0, retries=0; go to SEND.
  - SEND: when `busy_i`=0, drive `tx_data_o`=byte[idx] and pulse `tx_data_rdy_o`; go to WAIT. While `busy_i`=1, hold in SEND.
  - WAIT, on `tx_ok_i`: if idx=3, go to IDLE; otherwise idx+1, retries=0, go to SEND.
  - WAIT, on `tx_err_i` or timeout: retries+1.
    - If retries now equals MAX_RETRY, abort: increment `drop_cnt_o` (saturating) and go to IDLE.
    - Otherwise go to GAP.
  - WAIT, if `tx_ok_i` and `tx_err_i` arrive in the same cycle: `tx_err_i` wins.
  - GAP: count RETRY_GAP cycles, then go to SEND with the same idx.
- **Independence:** the buffer keeps accepting pushes in every state.

## Timing
- **Reset (async):**
  - Buffer empty; FSM in IDLE.
  - All outputs 0: `tx_data_rdy_o`, `tx_data_o`, `overflow_o`, `drop_cnt_o`, `level_o`, `frame_active_o`.
  - seq = 0, idx = 0, retries = 0.
  - Reset mid-frame discards the partial frame. No further request is issued.
- **Push:** `level_o` updates the cycle after `sample_valid_i`.
- **Latency:** a push into an empty buffer while idle produces `tx_data_rdy_o` for byte 0 at cycle +3 (push → IDLE pop → LOAD → SEND).
- **Request pulse:** `tx_data_rdy_o` is exactly one cycle wide and never asserted while `busy_i`=1. At most one request is outstanding at a time.
- **Next byte:** after `tx_ok_i` at cycle t, the next request is issued no earlier than t+1.
- **Retry:** after `tx_err_i` at cycle t, the retry request comes at t+1+RETRY_GAP+1.
- **Timeout:** fires when the WAIT cycle count reaches ACK_TIMEOUT (0 disables the timeout).

## Structure
- Shared header `packetizer_defs.vh`: SYNC_BYTE (0xA5), state encodings, frame length (4).
- Sub-module `sample_buffer`: synchronous circular FIFO, parameterised width/DEPTH.
  - Ports: push, pop, data in/out, full, empty, level.
  - Read/write pointers one bit wider than the address, so full and empty are distinguishable.
- Top-level wiring: connect directly to `fifo_interface`.
  - `tx_data_rdy_o`→`tx_data_rdy_i`; `tx_data_o`→`tx_data_i`.
  - `tx_ok_i`/`tx_err_i` from `tx_ok_o`/`tx_err_o`; `busy_i` from `busy_o`.

## Test plan
- Single sample 0x1234 with every byte acked 2 cycles after its request → bytes A5, 00, 12, 34 in order; `frame_active_o` returns to 0; `level_o` returns to 0.
- 20 samples pushed back-to-back with `tx_ok_i` withheld (DEPTH=16) → `level_o`=16 and `overflow_o`=1; the next frame's byte 1 has bit7=1; the frame after that has bit7=0.
- `tx_err_i` on byte 2 once, then ok → byte 2 re-sent exactly RETRY_GAP+2 cycles after the error; the frame completes; `drop_cnt_o`=0.
- `tx_err_i` three times on byte 1 → frame aborted, `drop_cnt_o`=1; the next frame starts with seq incremented by 1.
- `busy_i` held high for 50 cycles in SEND, then no ack → no request while busy; timeout after ACK_TIMEOUT cycles treated as an error and retried.
- Assert `reset_i` while in WAIT on byte 2 → all outputs 0 immediately; the next sample produces a frame with seq 0.
